// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - mole game sequencer: random patterns, shrinking hold window, fixed round count
module mole_spawner #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned MIN_HOLD    = 10_000_000,
    parameter int unsigned STEP_CYCLES = 2_000_000,
    parameter int unsigned ROUNDS      = 30,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] board_state,
    output logic       load,
    output logic [4:0] loadval,
    output logic [7:0] round,
    output logic       busy,
    output logic       game_over
);

    localparam int unsigned    TW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [15:0]    SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [TW-1:0]  HOLD_INIT = TW'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_HOLD,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q;
    logic [TW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      round_d;
    logic            load_d, busy_d, over_d;
    logic [4:0]      loadval_d;

    logic [31:0]     hold_wide;
    logic [TW-1:0]   hold_next;
    logic [4:0]      pattern;
    logic            early_clear;
    logic            last_round;
    logic            lfsr_fb;

    // Taps 16,14,13,11 in right-shift Fibonacci form; a nonzero seed never reaches 0.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    assign pattern = (lfsr_q[4:0] == 5'd0) ? 5'b00100 : lfsr_q[4:0];

    // Saturating shrink: compare before subtracting so the window never wraps.
    assign hold_wide = 32'(hold_q);
    assign hold_next = (hold_wide >= MIN_HOLD + STEP_CYCLES) ? TW'(hold_wide - STEP_CYCLES)
                                                            : TW'(MIN_HOLD);

    // The board takes two cycles to reflect a load, so its readback is trusted from HOLD cycle 3.
    assign early_clear = ((hold_q - timer_q) >= TW'(2)) && (board_state == 5'd0);
    assign last_round  = ({1'b0, round} + 9'd1) == 9'(ROUNDS);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        timer_d   = timer_q;
        round_d   = round;
        busy_d    = busy;
        over_d    = game_over;
        load_d    = 1'b0;
        loadval_d = 5'd0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_SPAWN;
                    round_d   = 8'd0;
                    hold_d    = HOLD_INIT;
                    busy_d    = 1'b1;
                    over_d    = 1'b0;
                    load_d    = 1'b1;
                    loadval_d = pattern;
                end
            end
            S_SPAWN: begin
                timer_d = hold_q;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                timer_d = timer_q - TW'(1);
                if (timer_q == TW'(1) || early_clear) begin
                    round_d = round + 8'd1;
                    hold_d  = hold_next;
                    load_d  = 1'b1;
                    if (last_round) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d   = S_SPAWN;
                        loadval_d = pattern;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                over_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                over_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            hold_q    <= HOLD_INIT;
            timer_q   <= '0;
            round     <= 8'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            load      <= 1'b0;
            loadval   <= 5'd0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= {lfsr_fb, lfsr_q[15:1]};
            hold_q    <= hold_d;
            timer_q   <= timer_d;
            round     <= round_d;
            busy      <= busy_d;
            game_over <= over_d;
            load      <= load_d;
            loadval   <= loadval_d;
        end
    end

endmodule
